// File: rtl/proc_pkg.sv
// Shared definitions for the processor control unit: opcodes, state encoding
// and small decode helpers used by the control FSM, datapath top and bench.
package proc_pkg;

  localparam int PROC_DATA_W = 9;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_e;

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Any opcode with the top bit set is undefined and retires as a NOP.
  function automatic logic is_illegal_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/proc_control_unit_dec3to8.sv
// 3-bit binary to one-hot-8 decoder; all outputs zero when disabled.
module dec3to8 (
  input  logic       en_i,
  input  logic [2:0] sel_i,
  output logic [7:0] onehot_o
);

  always_comb begin
    onehot_o = 8'h00;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/proc_control_unit.sv
// Multicycle control FSM: fetches an instruction word into IR in T0 and
// sequences bus selects and register load enables over T1..T3.
//
// state | meaning
// T0    | idle / fetch: IRin follows Run, IR captures DIN on Run
// T1    | execute mv/mvi/illegal (final cycle), or read Rx into A for add/sub
// T2    | add/sub: drive Ry onto the bus, capture ALU result into G
// T3    | add/sub: write G back into Rx
module proc_control_unit
  import proc_pkg::*;
#(
  parameter int DATA_W = PROC_DATA_W
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic              IRin,
  output logic [7:0]        Rin,
  output logic              Ain,
  output logic              Gin,
  output logic              AddSub,
  output logic [7:0]        SRout,
  output logic              SGout,
  output logic              SDout,
  output logic              Done,
  output logic              Illegal
);

  state_e     state_q, state_d;
  logic [8:0] ir_q;

  logic [2:0] op;
  logic [2:0] fld_x;
  logic [2:0] fld_y;
  logic [7:0] x_hot;
  logic [7:0] y_hot;

  assign op    = ir_q[8:6];
  assign fld_x = ir_q[5:3];
  assign fld_y = ir_q[2:0];

  dec3to8 u_dec_x (
    .en_i     (Resetn),
    .sel_i    (fld_x),
    .onehot_o (x_hot)
  );

  dec3to8 u_dec_y (
    .en_i     (Resetn),
    .sel_i    (fld_y),
    .onehot_o (y_hot)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == T0 && Run) begin
        ir_q <= DIN[8:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    IRin    = 1'b0;
    Rin     = 8'h00;
    Ain     = 1'b0;
    Gin     = 1'b0;
    AddSub  = 1'b0;
    SRout   = 8'h00;
    SGout   = 1'b0;
    SDout   = 1'b0;
    Done    = 1'b0;
    Illegal = 1'b0;

    case (state_q)
      T0: begin
        IRin = Run;
        if (Run) begin
          state_d = T1;
        end
      end

      T1: begin
        if (is_illegal_op(op)) begin
          Done    = 1'b1;
          Illegal = 1'b1;
          state_d = T0;
        end else if (is_alu_op(op)) begin
          SRout   = x_hot;
          Ain     = 1'b1;
          state_d = T2;
        end else if (op == OP_MVI) begin
          SDout   = 1'b1;
          Rin     = x_hot;
          Done    = 1'b1;
          state_d = T0;
        end else begin
          SRout   = y_hot;
          Rin     = x_hot;
          Done    = 1'b1;
          state_d = T0;
        end
      end

      T2: begin
        SRout   = y_hot;
        Gin     = 1'b1;
        AddSub  = op[0];
        state_d = T3;
      end

      T3: begin
        SGout   = 1'b1;
        Rin     = x_hot;
        Done    = 1'b1;
        state_d = T0;
      end

      default: state_d = T0;
    endcase

    // Outputs are held quiet for the whole reset window, including IRin.
    if (!Resetn) begin
      IRin    = 1'b0;
      Rin     = 8'h00;
      Ain     = 1'b0;
      Gin     = 1'b0;
      AddSub  = 1'b0;
      SRout   = 8'h00;
      SGout   = 1'b0;
      SDout   = 1'b0;
      Done    = 1'b0;
      Illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_proc_control_unit.sv
// Scoreboard bench for proc_control_unit: a per-instruction micro-op model
// queues expected outputs per cycle; a negedge monitor pops and compares.
module tb_proc_control_unit;
  import proc_pkg::*;

  typedef struct packed {
    logic       irin;
    logic [7:0] rin;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic [7:0] srout;
    logic       sgout;
    logic       sdout;
    logic       done;
    logic       illegal;
  } outs_t;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Run;
  logic [8:0] DIN;
  logic       IRin;
  logic [7:0] Rin;
  logic       Ain;
  logic       Gin;
  logic       AddSub;
  logic [7:0] SRout;
  logic       SGout;
  logic       SDout;
  logic       Done;
  logic       Illegal;

  int checks = 0;
  int errors = 0;
  outs_t exp_q[$];

  proc_control_unit #(.DATA_W(9)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Run     (Run),
    .DIN     (DIN),
    .IRin    (IRin),
    .Rin     (Rin),
    .Ain     (Ain),
    .Gin     (Gin),
    .AddSub  (AddSub),
    .SRout   (SRout),
    .SGout   (SGout),
    .SDout   (SDout),
    .Done    (Done),
    .Illegal (Illegal)
  );

  always #5 Clock = ~Clock;

  function automatic outs_t sample();
    return {IRin, Rin, Ain, Gin, AddSub, SRout, SGout, SDout, Done, Illegal};
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compare queued expectations and bus invariants every active cycle.
  always @(negedge Clock) begin
    if (Resetn === 1'b1) begin
      if (exp_q.size() > 0) begin
        outs_t e;
        e = exp_q.pop_front();
        check("outputs{irin,rin,ain,gin,addsub,srout,sgout,sdout,done,illegal}",
              32'(sample()), 32'(e));
      end
      check("bus_exclusive", 32'(($countones(SRout) + SGout + SDout) <= 1), 32'd1);
      check("srout_onehot0", 32'($onehot0(SRout)), 32'd1);
      check("rin_onehot0",   32'($onehot0(Rin)),   32'd1);
    end
  end

  task automatic cycle(input logic r, input logic [8:0] d, input outs_t e);
    Run = r;
    DIN = d;
    exp_q.push_back(e);
    @(posedge Clock);
    #1;
  endtask

  function automatic logic pick_run(input int mode);
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'(mode);
  endfunction

  // Reference: the architectural micro-op list for one instruction.
  // run_mode: 0 = Run low after fetch, 1 = Run high, 2 = random.
  task automatic do_instr(input logic [8:0] w, input logic [8:0] imm, input int run_mode);
    logic [2:0] op;
    logic [7:0] rx, ry;
    outs_t e;
    op = w[8:6];
    rx = 8'd1 << w[5:3];
    ry = 8'd1 << w[2:0];
    e = '0;
    e.irin = 1'b1;
    cycle(1'b1, w, e);
    if (op >= 3'd4) begin
      e = '0; e.done = 1'b1; e.illegal = 1'b1;
      cycle(pick_run(run_mode), imm, e);
    end else if (op == OP_MV) begin
      e = '0; e.srout = ry; e.rin = rx; e.done = 1'b1;
      cycle(pick_run(run_mode), imm, e);
    end else if (op == OP_MVI) begin
      e = '0; e.sdout = 1'b1; e.rin = rx; e.done = 1'b1;
      cycle(pick_run(run_mode), imm, e);
    end else begin
      e = '0; e.srout = rx; e.ain = 1'b1;
      cycle(pick_run(run_mode), imm, e);
      e = '0; e.srout = ry; e.gin = 1'b1; e.addsub = (op == OP_SUB);
      cycle(pick_run(run_mode), 9'($urandom), e);
      e = '0; e.sgout = 1'b1; e.rin = rx; e.done = 1'b1;
      cycle(pick_run(run_mode), 9'($urandom), e);
    end
  endtask

  initial begin
    outs_t e;
    Resetn = 1'b0;
    Run    = 1'b1;
    DIN    = 9'o777;
    #3;
    check("reset_outputs_zero", 32'(sample()), 32'd0);
    repeat (2) @(posedge Clock);
    #1;
    Resetn = 1'b1;
    Run    = 1'b0;
    cycle(1'b0, 9'd0, '0);

    // Reset asserted while an add sits in T2.
    e = '0; e.irin = 1'b1;
    cycle(1'b1, 9'o213, e);
    e = '0; e.srout = 8'h02; e.ain = 1'b1;
    cycle(1'b0, 9'd0, e);
    Run    = 1'b1;
    Resetn = 1'b0;
    #1;
    check("midreset_outputs_zero", 32'(sample()), 32'd0);
    check("midreset_state_t0", 32'(dut.state_q), 32'(T0));
    check("midreset_ir_zero", 32'(dut.ir_q), 32'd0);
    @(posedge Clock);
    #1;
    Run    = 1'b0;
    Resetn = 1'b1;
    @(posedge Clock);
    #1;
    check("postreset_state_t0", 32'(dut.state_q), 32'(T0));
    check("postreset_ir_zero", 32'(dut.ir_q), 32'd0);
    cycle(1'b0, 9'd0, '0);

    do_instr(9'o120, 9'd5, 0);     // mvi R2,#5
    cycle(1'b0, 9'd0, '0);
    do_instr(9'o072, 9'd0, 0);     // mv R7,R2
    do_instr(9'o331, 9'd0, 0);     // sub R3,R1 back-to-back
    do_instr(9'o544, 9'd0, 1);     // illegal, Run held high
    do_instr(9'o266, 9'd0, 2);     // add R6,R6 with Run toggling
    do_instr(9'o044, 9'd0, 1);     // mv R4,R4
    do_instr(9'o777, 9'd0, 0);     // illegal
    cycle(1'b0, 9'd0, '0);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) cycle(1'b0, 9'($urandom), '0);
      do_instr(9'($urandom), 9'($urandom), 2);
    end

    cycle(1'b0, 9'd0, '0);
    cycle(1'b0, 9'd0, '0);
    @(negedge Clock);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
